// File: rtl/pipe_stage_reg_pkg.sv
// Shared types and constants for pipeline stage registers.
// The SKID state is only reachable in PIPE_SKID_EN builds.
package pipe_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FULL  = 2'd1,
    SKID  = 2'd2
  } pipe_state_t;

  localparam int DEF_CTRL_W = 8;
  localparam int DEF_DATA_W = 160;
  localparam int DEF_CNT_W  = 16;

  // Control-word bit positions, packed by the stage that feeds each boundary
  localparam int IDEX_REG_WRITE  = 0;
  localparam int IDEX_MEM_READ   = 1;
  localparam int IDEX_MEM_WRITE  = 2;
  localparam int IDEX_MEM_TO_REG = 3;
  localparam int IDEX_ALU_SRC    = 4;
  localparam int IDEX_BRANCH     = 5;
  localparam int IDEX_ALU_OP_LO  = 6;
  localparam int IDEX_ALU_OP_HI  = 7;

  localparam int EXMEM_REG_WRITE  = 0;
  localparam int EXMEM_MEM_READ   = 1;
  localparam int EXMEM_MEM_WRITE  = 2;
  localparam int EXMEM_MEM_TO_REG = 3;
  localparam int EXMEM_BRANCH     = 4;

  localparam int MEMWB_REG_WRITE  = 0;
  localparam int MEMWB_MEM_TO_REG = 1;

  localparam int IFID_PRED_TAKEN  = 0;
  localparam int IFID_EXCEPTION   = 1;

  function automatic logic isOccupied(input pipe_state_t s);
    return s != EMPTY;
  endfunction

endpackage

// File: rtl/pipe_stage_reg_if.sv
// Upstream/downstream valid-ready channel pair of one stage boundary.
// master = surrounding pipeline, slave = the stage register itself.
interface pipe_stage_reg_if
  import pipe_pkg::*;
#(
  parameter int CTRL_W = DEF_CTRL_W,
  parameter int DATA_W = DEF_DATA_W
);

  logic              in_valid;
  logic              in_ready;
  logic [CTRL_W-1:0] in_ctrl;
  logic [DATA_W-1:0] in_data;

  logic              out_valid;
  logic              out_ready;
  logic [CTRL_W-1:0] out_ctrl;
  logic [DATA_W-1:0] out_data;

  modport master (
    output in_valid, in_ctrl, in_data, out_ready,
    input  in_ready, out_valid, out_ctrl, out_data
  );

  modport slave (
    input  in_valid, in_ctrl, in_data, out_ready,
    output in_ready, out_valid, out_ctrl, out_data
  );

endinterface

// File: rtl/pipe_stage_reg_sat_counter.sv
// Saturating up-counter; holds at all-ones instead of wrapping.
module pipe_sat_counter
  import pipe_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc_i,
  output logic [CNT_W-1:0] count_o
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (inc_i && (count_q != {CNT_W{1'b1}})) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Valid/ready pipeline stage register with flush, bubble ctrl zeroing and stall counter.
// Define PIPE_SKID_EN for a 2-entry skid buffer with registered in_ready.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int CTRL_W = DEF_CTRL_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  pipe_stage_reg_if.slave  bus,
  output logic [CNT_W-1:0] stall_cnt
);

  pipe_state_t       state_q;
  pipe_state_t       state_d;

  logic [CTRL_W-1:0] mainCtrl_q;
  logic [CTRL_W-1:0] mainCtrl_d;
  logic [DATA_W-1:0] mainData_q;
  logic [DATA_W-1:0] mainData_d;

  logic outValid;
  logic inReady;
  logic accept;
  logic drain;
  logic stallInc;

`ifdef PIPE_SKID_EN
  logic [CTRL_W-1:0] skidCtrl_q;
  logic [CTRL_W-1:0] skidCtrl_d;
  logic [DATA_W-1:0] skidData_q;
  logic [DATA_W-1:0] skidData_d;
  logic              inReady_q;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      EMPTY: begin
        if (accept) state_d = FULL;
      end
      FULL: begin
        if (drain && !accept) begin
          state_d = EMPTY;
        end
`ifdef PIPE_SKID_EN
        else if (accept && !drain) begin
          state_d = SKID;
        end
`endif
      end
`ifdef PIPE_SKID_EN
      SKID: begin
        if (drain) state_d = FULL;
      end
`endif
      default: state_d = EMPTY;
    endcase
    if (flush) state_d = EMPTY;
  end

  always_comb begin
    outValid = isOccupied(state_q);
`ifdef PIPE_SKID_EN
    inReady  = inReady_q;
`else
    inReady  = !outValid || bus.out_ready;
`endif
    accept   = bus.in_valid && inReady;
    drain    = outValid && bus.out_ready;
    stallInc = outValid && !bus.out_ready && !flush;
  end

  // Data moves only when an entry actually lands; empty slots keep stale data.
  always_comb begin
    mainCtrl_d = mainCtrl_q;
    mainData_d = mainData_q;
`ifdef PIPE_SKID_EN
    skidCtrl_d = skidCtrl_q;
    skidData_d = skidData_q;
`endif
    if (!flush) begin
`ifdef PIPE_SKID_EN
      if (state_q == SKID) begin
        if (drain) begin
          mainCtrl_d = skidCtrl_q;
          mainData_d = skidData_q;
        end
      end else if (accept && outValid && !drain) begin
        skidCtrl_d = bus.in_ctrl;
        skidData_d = bus.in_data;
      end else if (accept) begin
        mainCtrl_d = bus.in_ctrl;
        mainData_d = bus.in_data;
      end
`else
      if (accept) begin
        mainCtrl_d = bus.in_ctrl;
        mainData_d = bus.in_data;
      end
`endif
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mainCtrl_q <= '0;
      mainData_q <= '0;
    end else begin
      mainCtrl_q <= mainCtrl_d;
      mainData_q <= mainData_d;
    end
  end

`ifdef PIPE_SKID_EN
  // in_ready comes straight from a flop so it never chains across stages
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      skidCtrl_q <= '0;
      skidData_q <= '0;
      inReady_q  <= 1'b1;
    end else begin
      skidCtrl_q <= skidCtrl_d;
      skidData_q <= skidData_d;
      inReady_q  <= (state_d != SKID);
    end
  end
`endif

  assign bus.in_ready  = inReady;
  assign bus.out_valid = outValid;
  assign bus.out_ctrl  = outValid ? mainCtrl_q : '0;
  assign bus.out_data  = mainData_q;

  pipe_sat_counter #(
    .CNT_W (CNT_W)
  ) u_stallCnt (
    .clk     (clk),
    .reset   (reset),
    .inc_i   (stallInc),
    .count_o (stall_cnt)
  );

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Randomised and directed bench for pipe_stage_reg against a queue-based model.
// A second instance with a 4-bit stall counter shares the stimulus to exercise saturation.
module tb_pipe_stage_reg;
  import pipe_pkg::*;

  localparam int CTRL_W = 8;
  localparam int DATA_W = 160;
  localparam int CNT_W  = 16;
  localparam int SAT_W  = 4;

  typedef struct {
    logic [CTRL_W-1:0] ctrl;
    logic [DATA_W-1:0] data;
  } entry_t;

  logic clk = 1'b0;
  logic rstN;
  logic flush;
  logic [CNT_W-1:0] stallCnt;
  logic [SAT_W-1:0] stallCntSat;

  entry_t            modelQ[$];
  int unsigned       stallModel;
  logic [DATA_W-1:0] modelData;
  int                checkCount = 0;
  int                passCount  = 0;
  int                failCount  = 0;

  pipe_stage_reg_if #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) bus ();
  pipe_stage_reg_if #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) busSat ();

  pipe_stage_reg #(.CTRL_W(CTRL_W), .DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .reset     (rstN),
    .flush     (flush),
    .bus       (bus),
    .stall_cnt (stallCnt)
  );

  pipe_stage_reg #(.CTRL_W(CTRL_W), .DATA_W(DATA_W), .CNT_W(SAT_W)) dutSat (
    .clk       (clk),
    .reset     (rstN),
    .flush     (flush),
    .bus       (busSat),
    .stall_cnt (stallCntSat)
  );

  always #5 clk = ~clk;

  function automatic logic [DATA_W-1:0] randData();
    return {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // A stage holds one entry (two with the skid buffer) and forwards them in order
  function automatic logic modelReady(input logic oRdy);
`ifdef PIPE_SKID_EN
    return modelQ.size() < 2;
`else
    return (modelQ.size() == 0) || oRdy;
`endif
  endfunction

  function automatic int unsigned satAt(input int unsigned v, input int unsigned maxV);
    return (v > maxV) ? maxV : v;
  endfunction

  task automatic modelReset();
    modelQ.delete();
    stallModel = 0;
    modelData  = '0;
  endtask

  task automatic checkOutput(input string tag, input logic [255:0] observed, input logic [255:0] expected);
    checkCount++;
    assert (observed === expected) passCount = passCount + 1;
    else begin
      failCount++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic checkState();
    logic              expValid;
    logic [CTRL_W-1:0] expCtrl;
    expValid = modelQ.size() > 0;
    expCtrl  = expValid ? modelQ[0].ctrl : '0;
    checkOutput("out_valid", 256'(bus.out_valid), 256'(expValid));
    checkOutput("out_ctrl", 256'(bus.out_ctrl), 256'(expCtrl));
    checkOutput("out_data", 256'(bus.out_data), 256'(modelData));
    checkOutput("stall_cnt", 256'(stallCnt), 256'(satAt(stallModel, 65535)));
    checkOutput("sat_out_data", 256'(busSat.out_data), 256'(modelData));
    checkOutput("sat_stall_cnt", 256'(stallCntSat), 256'(satAt(stallModel, 15)));
  endtask

  // Called just after a rising edge; drives one cycle and checks the result after the next edge
  task automatic applyStimulus(input logic v, input logic [CTRL_W-1:0] c, input logic [DATA_W-1:0] d,
                               input logic oRdy, input logic fl);
    logic expReady;
    bus.in_valid     = v;
    bus.in_ctrl      = c;
    bus.in_data      = d;
    bus.out_ready    = oRdy;
    busSat.in_valid  = v;
    busSat.in_ctrl   = c;
    busSat.in_data   = d;
    busSat.out_ready = oRdy;
    flush            = fl;
    #1;
    expReady = modelReady(oRdy);
    checkOutput("in_ready", 256'(bus.in_ready), 256'(expReady));
    checkOutput("sat_in_ready", 256'(busSat.in_ready), 256'(expReady));
    @(posedge clk);
    if (!rstN) begin
      modelReset();
    end else begin
      if ((modelQ.size() > 0) && !oRdy && !fl) stallModel++;
      if (fl) begin
        modelQ.delete();
      end else begin
        if ((modelQ.size() > 0) && oRdy) void'(modelQ.pop_front());
        if (v && expReady) modelQ.push_back('{ctrl: c, data: d});
      end
      if (modelQ.size() > 0) modelData = modelQ[0].data;
    end
    #1;
    checkState();
  endtask

  initial begin
    rstN  = 1'b0;
    flush = 1'b0;
    modelReset();
    bus.in_valid = 1'b0;  bus.in_ctrl = '0;  bus.in_data = '0;  bus.out_ready = 1'b0;
    busSat.in_valid = 1'b0;  busSat.in_ctrl = '0;  busSat.in_data = '0;  busSat.out_ready = 1'b0;
    @(posedge clk);
    #1;

    $display("[TB] reset with live input");
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 8'hFF, randData(), 1'b1, 1'b0);
    rstN = 1'b1;
    applyStimulus(1'b0, 8'h00, '0, 1'b1, 1'b0);
    checkOutput("reset_no_capture", 256'(bus.out_valid), 256'(0));

    $display("[TB] back-to-back stream");
    for (int i = 1; i <= 10; i++) begin
      applyStimulus(1'b1, CTRL_W'($urandom()), DATA_W'(i), 1'b1, 1'b0);
      checkOutput("stream_data", 256'(bus.out_data), 256'(i));
    end
    applyStimulus(1'b0, 8'h00, randData(), 1'b1, 1'b0);

    $display("[TB] back-pressure");
    applyStimulus(1'b1, 8'h5A, randData(), 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, CTRL_W'($urandom()), randData(), 1'b0, 1'b0);
    checkOutput("stall_5", 256'(stallCnt), 256'(5));
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 8'h00, randData(), 1'b1, 1'b0);

    $display("[TB] flush with same-cycle input");
    applyStimulus(1'b1, 8'hC3, randData(), 1'b1, 1'b0);
    applyStimulus(1'b1, 8'h3C, randData(), 1'b1, 1'b1);
    checkOutput("flush_valid", 256'(bus.out_valid), 256'(0));
    applyStimulus(1'b1, 8'hA5, randData(), 1'b0, 1'b0);
    applyStimulus(1'b1, 8'h96, randData(), 1'b0, 1'b0);
    applyStimulus(1'b1, 8'h69, randData(), 1'b0, 1'b1);
    checkOutput("flush_ctrl", 256'(bus.out_ctrl), 256'(0));

    $display("[TB] random traffic");
    for (int i = 0; i < 400; i++) begin
      applyStimulus(1'($urandom_range(0, 3) != 0), CTRL_W'($urandom()), randData(),
                    1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 19) == 0));
    end

    $display("[TB] counter saturation");
    rstN = 1'b0;
    modelReset();
    applyStimulus(1'b0, 8'h00, '0, 1'b1, 1'b0);
    rstN = 1'b1;
    applyStimulus(1'b1, 8'h11, randData(), 1'b1, 1'b0);
    for (int i = 0; i < 20; i++) applyStimulus(1'b0, 8'h00, randData(), 1'b0, 1'b0);
    checkOutput("sat_15", 256'(stallCntSat), 256'(15));
    checkOutput("wide_20", 256'(stallCnt), 256'(20));

    $display("[TB] async reset mid-stall");
    #3;
    rstN = 1'b0;
    modelReset();
    #1;
    checkOutput("async_valid", 256'(bus.out_valid), 256'(0));
    checkOutput("async_ctrl", 256'(bus.out_ctrl), 256'(0));
    checkOutput("async_data", 256'(bus.out_data), 256'(0));
    checkOutput("async_stall", 256'(stallCnt), 256'(0));
    checkOutput("async_sat_stall", 256'(stallCntSat), 256'(0));
    checkOutput("async_in_ready", 256'(bus.in_ready), 256'(1));
    @(posedge clk);
    #1;
    rstN = 1'b1;
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, CTRL_W'($urandom()), randData(), 1'b1, 1'b0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
